// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage (master) and the data memory (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I MEM stage: issues aligned loads/stores over a valid/ready bus, extends load data,
// and registers the MEM/WB fields. Stalls upstream while an access is outstanding.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [2:0]            funct3_i,
    input  logic [31:0]           alu_out_i,
    input  logic [31:0]           store_data_i,
    input  logic [31:0]           next_sel_address_i,
    input  logic [1:0]            mem_to_reg_i,
    input  logic [4:0]            rd_i,
    input  logic                  reg_write_i,
    output logic                  stall_o,
    mem_access_unit_if.master     dmem,
    output logic                  wb_valid_o,
    output logic [31:0]           wb_alu_out_o,
    output logic [31:0]           wb_data_mem_out_o,
    output logic [31:0]           wb_next_sel_address_o,
    output logic [1:0]            wb_mem_to_reg_o,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_reg_write_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic [3:0] store_strb(logic we, logic [1:0] size, logic [1:0] off);
        if (!we) return 4'b0000;
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(logic [1:0] size, logic [31:0] sd);
        case (size)
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(logic [31:0] w, logic [1:0] off, logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    logic [0:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic [31:0] addr_q, wdata_q, nsa_q;
    logic        we_q, rw_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  f3_q;
    logic [1:0]  m2r_q;
    logic [4:0]  rd_q;

    logic        wb_valid_q, wb_rw_q, wb_mis_q, wb_berr_q;
    logic [31:0] wb_alu_q, wb_data_q, wb_nsa_q;
    logic [1:0]  wb_m2r_q;
    logic [4:0]  wb_rd_q;

    logic        mem_op, misal, busy, timeout_hit, latch_en, from_busy;
    logic        wb_valid_d, wb_rw_d, wb_mis_d, wb_berr_d;
    logic [31:0] wb_data_d;
    logic [1:0]  size_in;

    assign mem_op      = mem_read_i | mem_write_i;
    assign size_in     = funct3_i[1:0];
    // Sizes 10 and 11 are both word accesses (unlisted load encodings behave as LW).
    assign misal       = ((size_in == 2'b01) & alu_out_i[0]) | (size_in[1] & (|alu_out_i[1:0]));
    assign busy        = (state_q == BUSY);
    assign timeout_hit = busy & ~dmem.dmem_ready & (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch_en   = 1'b0;
        from_busy  = 1'b0;
        stall_o    = 1'b0;
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_mis_d   = 1'b0;
        wb_berr_d  = 1'b0;
        wb_data_d  = 32'd0;
        case (state_q)
            IDLE: begin
                if (ex_valid_i) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = reg_write_i;
                    end else if (misal) begin
                        wb_valid_d = 1'b1;
                        wb_mis_d   = 1'b1;
                    end else begin
                        stall_o  = 1'b1;
                        latch_en = 1'b1;
                        cnt_d    = 16'd0;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmem_ready) begin
                    wb_valid_d = 1'b1;
                    from_busy  = 1'b1;
                    wb_rw_d    = rw_q;
                    wb_data_d  = we_q ? 32'd0 : load_extract(dmem.dmem_rdata, addr_q[1:0], f3_q);
                    cnt_d      = 16'd0;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    // The aborted op retires with an error so the upstream can advance.
                    wb_valid_d = 1'b1;
                    from_busy  = 1'b1;
                    wb_berr_d  = 1'b1;
                    cnt_d      = 16'd0;
                    state_d    = IDLE;
                end else begin
                    stall_o = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            addr_q  <= alu_out_i;
            we_q    <= mem_write_i;
            wdata_q <= store_lanes(size_in, store_data_i);
            wstrb_q <= store_strb(mem_write_i, size_in, alu_out_i[1:0]);
            f3_q    <= funct3_i;
            nsa_q   <= next_sel_address_i;
            m2r_q   <= mem_to_reg_i;
            rd_q    <= rd_i;
            rw_q    <= reg_write_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 16'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_mis_q   <= 1'b0;
            wb_berr_q  <= 1'b0;
            wb_alu_q   <= 32'd0;
            wb_data_q  <= 32'd0;
            wb_nsa_q   <= 32'd0;
            wb_m2r_q   <= 2'd0;
            wb_rd_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_mis_q   <= wb_mis_d;
            wb_berr_q  <= wb_berr_d;
            if (wb_valid_d) begin
                wb_alu_q  <= from_busy ? addr_q : alu_out_i;
                wb_nsa_q  <= from_busy ? nsa_q  : next_sel_address_i;
                wb_m2r_q  <= from_busy ? m2r_q  : mem_to_reg_i;
                wb_rd_q   <= from_busy ? rd_q   : rd_i;
                wb_data_q <= wb_data_d;
            end
        end
    end

    assign dmem.dmem_req   = busy;
    assign dmem.dmem_we    = busy & we_q;
    assign dmem.dmem_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem.dmem_wdata = busy ? wdata_q : 32'd0;
    assign dmem.dmem_wstrb = busy ? wstrb_q : 4'd0;

    assign wb_valid_o            = wb_valid_q;
    assign wb_alu_out_o          = wb_alu_q;
    assign wb_data_mem_out_o     = wb_data_q;
    assign wb_next_sel_address_o = wb_nsa_q;
    assign wb_mem_to_reg_o       = wb_m2r_q;
    assign wb_rd_o               = wb_rd_q;
    assign wb_reg_write_o        = wb_rw_q;
    assign misaligned_o          = wb_mis_q;
    assign bus_err_o             = wb_berr_q;
endmodule
